// File: rtl/newspaper_pkg.sv
// Shared constants and types for the newspaper vending controller.
package newspaper_pkg;

    // All amounts are in cents; 6 bits covers the largest possible total (55).
    localparam logic [5:0] PRICE   = 6'd35;
    localparam logic [5:0] NICKEL  = 6'd5;
    localparam logic [5:0] DIME    = 6'd10;
    localparam logic [5:0] QUARTER = 6'd25;

    // Accumulated credit; the register never holds PRICE or more.
    typedef enum logic [2:0] {
        C0  = 3'd0,
        C5  = 3'd1,
        C10 = 3'd2,
        C15 = 3'd3,
        C20 = 3'd4,
        C25 = 3'd5,
        C30 = 3'd6
    } credit_e;

    // Change owed after a vend, 0..20 cents.
    typedef logic [4:0] change_t;

    function automatic logic [5:0] credit_cents(input credit_e c);
        logic [5:0] cents;
        case (c)
            C0:      cents = 6'd0;
            C5:      cents = 6'd5;
            C10:     cents = 6'd10;
            C15:     cents = 6'd15;
            C20:     cents = 6'd20;
            C25:     cents = 6'd25;
            C30:     cents = 6'd30;
            default: cents = 6'd0;
        endcase
        return cents;
    endfunction

    // Only called with totals below PRICE; anything else collapses to C0.
    function automatic credit_e cents_to_credit(input logic [5:0] cents);
        credit_e c;
        case (cents)
            6'd5:    c = C5;
            6'd10:   c = C10;
            6'd15:   c = C15;
            6'd20:   c = C20;
            6'd25:   c = C25;
            6'd30:   c = C30;
            default: c = C0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/newspaper_change_enc.sv
// Maps a change amount to the coin-return solenoid pattern.
// Twenty cents is returned as two dimes, so D1 and D2 are never both set.
module newspaper_change_enc
    import newspaper_pkg::*;
(
    input  change_t    change_amt,
    output logic       n1,
    output logic       d1,
    output logic       d2
);

    // Decode the amount; unexpected amounts return nothing.
    always_comb begin
        n1 = 1'b0;
        d1 = 1'b0;
        d2 = 1'b0;
        case (change_amt)
            5'd5:  n1 = 1'b1;
            5'd10: d1 = 1'b1;
            5'd15: begin
                d1 = 1'b1;
                n1 = 1'b1;
            end
            5'd20: d2 = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/newspaper_vendor.sv
// Coin-operated newspaper vending controller: accumulates nickels, dimes and
// quarters toward a 35c price, then pulses release plus exact change.
//
// state | meaning
// C0    | no credit
// C5    | 5c credit
// C10   | 10c credit
// C15   | 15c credit
// C20   | 20c credit
// C25   | 25c credit
// C30   | 30c credit
//
// A completing coin returns the FSM to C0 in the same edge that loads the
// output pulses, so a coin in the following cycle starts a fresh sale.
module newspaper_vendor
    import newspaper_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic N,
    input  logic D,
    input  logic Q,
    output logic R,
    output logic N1,
    output logic D1,
    output logic D2
);

    credit_e    credit_q, credit_d;
    logic       r_q, r_d;
    logic       n1_q, n1_d;
    logic       d1_q, d1_d;
    logic       d2_q, d2_d;

    logic [5:0] coin_val;
    logic [5:0] total;
    change_t    change_amt;
    logic       enc_n1, enc_d1, enc_d2;

    // Coin decode: exactly one input high counts, any other pattern is no coin.
    always_comb begin
        coin_val = 6'd0;
        case ({N, D, Q})
            3'b100:  coin_val = NICKEL;
            3'b010:  coin_val = DIME;
            3'b001:  coin_val = QUARTER;
            default: coin_val = 6'd0;
        endcase
        total = credit_cents(credit_q) + coin_val;
    end

    // Next credit and output pulses from the running total.
    always_comb begin
        credit_d   = credit_q;
        r_d        = 1'b0;
        change_amt = '0;
        if (coin_val != 6'd0) begin
            if (total >= PRICE) begin
                credit_d   = C0;
                r_d        = 1'b1;
                change_amt = change_t'(total - PRICE);
            end else begin
                credit_d   = cents_to_credit(total);
            end
        end
        n1_d = enc_n1;
        d1_d = enc_d1;
        d2_d = enc_d2;
    end

    newspaper_change_enc u_change_enc (
        .change_amt (change_amt),
        .n1         (enc_n1),
        .d1         (enc_d1),
        .d2         (enc_d2)
    );

    // Credit state register and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= C0;
            r_q      <= 1'b0;
            n1_q     <= 1'b0;
            d1_q     <= 1'b0;
            d2_q     <= 1'b0;
        end else begin
            credit_q <= credit_d;
            r_q      <= r_d;
            n1_q     <= n1_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
        end
    end

    assign R  = r_q;
    assign N1 = n1_q;
    assign D1 = d1_q;
    assign D2 = d2_q;

endmodule

// File: tb/tb_newspaper_vendor.sv
// Directed bench for newspaper_vendor. Outputs are compared as {R,N1,D1,D2}.
module tb_newspaper_vendor;

    logic clk;
    logic rst_n;
    logic N, D, Q;
    logic R, N1, D1, D2;

    int checks;
    int errors;

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_N    = 3'b100;
    localparam logic [2:0] C_D    = 3'b010;
    localparam logic [2:0] C_Q    = 3'b001;
    localparam logic [2:0] C_ND   = 3'b110;

    localparam logic [3:0] O_NONE = 4'b0000;
    localparam logic [3:0] O_R    = 4'b1000;
    localparam logic [3:0] O_R15  = 4'b1110;
    localparam logic [3:0] O_R20  = 4'b1001;
    localparam logic [3:0] O_R5   = 4'b1100;

    newspaper_vendor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .N     (N),
        .D     (D),
        .Q     (Q),
        .R     (R),
        .N1    (N1),
        .D1    (D1),
        .D2    (D2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got RN1D1D2=%b expected %b", tag, obs, exp);
        end
    endtask

    // Present one coin pattern for one edge, then compare at the next falling edge.
    task automatic step(input string tag, input logic [2:0] ndq, input logic [3:0] exp);
        {N, D, Q} = ndq;
        @(posedge clk);
        @(negedge clk);
        {N, D, Q} = C_NONE;
        chk(tag, {R, N1, D1, D2}, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        {N, D, Q} = C_Q;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {R, N1, D1, D2}, O_NONE);
        {N, D, Q} = C_NONE;
        rst_n = 1'b1;

        // Quarter during reset must not have stuck: D,idle,Q is exactly 35.
        step("dq_d",     C_D,    O_NONE);
        step("dq_idle",  C_NONE, O_NONE);
        step("dq_q",     C_Q,    O_R);
        step("dq_after", C_NONE, O_NONE);

        step("ndnnq_n1", C_N, O_NONE);
        step("ndnnq_d",  C_D, O_NONE);
        step("ndnnq_n2", C_N, O_NONE);
        step("ndnnq_n3", C_N, O_NONE);
        step("ndnnq_q",  C_Q, O_R15);

        // Coin in the R cycle starts from credit 0.
        step("qnq_q1", C_Q, O_NONE);
        step("qnq_n",  C_N, O_NONE);
        step("qnq_q2", C_Q, O_R20);

        step("qd_q", C_Q, O_NONE);
        step("qd_d", C_D, O_R);

        step("dddn_d1", C_D, O_NONE);
        step("dddn_d2", C_D, O_NONE);
        step("dddn_d3", C_D, O_NONE);
        step("dddn_n",  C_N, O_R);

        step("qq_q1", C_Q, O_NONE);
        step("qq_q2", C_Q, O_R15);
        step("qq_q3", C_Q, O_NONE);
        step("qq_q4", C_Q, O_R15);
        step("qq_idle", C_NONE, O_NONE);

        // Two inputs together are ignored; 25 + 10 then vends with no change.
        step("multi_nd", C_ND, O_NONE);
        step("multi_q",  C_Q,  O_NONE);
        step("multi_d",  C_D,  O_R);

        // Reset while a pulse is visible clears outputs asynchronously.
        step("rstpulse_q1", C_Q, O_NONE);
        step("rstpulse_q2", C_Q, O_R15);
        #2 rst_n = 1'b0;
        #1 chk("rstpulse_async", {R, N1, D1, D2}, O_NONE);
        @(negedge clk);
        rst_n = 1'b1;

        // Credit 30 then reset: credit must be lost.
        step("rst30_q", C_Q, O_NONE);
        step("rst30_n", C_N, O_NONE);
        #2 rst_n = 1'b0;
        #1 chk("rst30_async", {R, N1, D1, D2}, O_NONE);
        @(negedge clk);
        chk("rst30_held", {R, N1, D1, D2}, O_NONE);
        rst_n = 1'b1;
        step("rst30_d", C_D, O_NONE);
        step("rst30_qv", C_Q, O_R);
        step("rst30_idle", C_NONE, O_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
